cheshire_uart_rx: RTL

CHESHIRE_UART_RX -- requirements
Module: cheshire_uart_rx

---
 rtl/cheshire_uart_rx_pkg.sv | 22 ++
 rtl/cheshire_uart_rx_fifo.sv | 73 +++++++
 rtl/cheshire_uart_rx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cheshire_uart_rx_pkg.sv
// Shared definitions for the cheshire UART receiver.
//   DataWidth : bits per received character
//   MinDiv    : smallest bit-period divisor the receiver will use
//   state_e   : receiver FSM states (PARITY exists only when
//               CHESHIRE_UART_RX_PARITY_EN is defined)
package cheshire_uart_rx_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned MinDiv    = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef CHESHIRE_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_e;

endpackage

// File: rtl/cheshire_uart_rx_fifo.sv
// Byte FIFO used by the UART receiver (fifo_v3 interface subset,
// synchronous active-low reset, no fall-through).
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   full_o, empty_o   : occupancy flags
//   data_i, push_i    : write side; a push while full is accepted only
//                       when a pop happens in the same cycle
//   data_o, pop_i     : read side; data_o reads 0 while empty
module fifo_v3
    import cheshire_uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidth,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AddrW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [AddrW:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push_do, pop_do;

    assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_do  = pop_i & ~empty_o;
    // A full FIFO can still take a byte when the head leaves this cycle.
    assign push_do = push_i & (~full_o | pop_do);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop_do) begin
            rd_d = rd_q + AddrW'(1);
        end
        if (push_do) begin
            wr_d = wr_q + AddrW'(1);
        end
        if (push_do && !pop_do) begin
            cnt_d = cnt_q + (AddrW+1)'(1);
        end else if (pop_do && !push_do) begin
            cnt_d = cnt_q - (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_do) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cheshire_uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, optional parity,
// followed by a byte FIFO with a valid/ready read port.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   en_i           : when low no new frame is started
//   clk_div_i      : clk_i cycles per bit (values below 4 are raised to 4),
//                    latched at the start edge of each frame
//   uart_rx_i      : asynchronous serial line, idle high
//   data_o/valid_o/ready_i : FIFO head and handshake
//   busy_o         : frame in progress
//   frame_err_o    : pulse, stop bit sampled low
//   overrun_o      : pulse, good byte dropped because the FIFO was full
//   parity_en_i, parity_odd_i, parity_err_o : present only when the macro
//                    CHESHIRE_UART_RX_PARITY_EN is defined
module cheshire_uart_rx
    import cheshire_uart_rx_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned DivWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DivWidth-1:0]  clk_div_i,
    input  logic                 uart_rx_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
`ifdef CHESHIRE_UART_RX_PARITY_EN
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic                 parity_err_o,
`endif
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    state_e                state_q, state_d;
    logic [1:0]            rx_sync_q;
    logic                  rx_s, rx_prev_q;
    logic [DivWidth-1:0]   cnt_q, cnt_d, div_q, div_d;
    logic [2:0]            bit_q, bit_d;
    logic [DataWidth-1:0]  shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  push_req, fifo_full, fifo_empty, pop;
    logic                  half_hit, full_hit;
`ifdef CHESHIRE_UART_RX_PARITY_EN
    logic                  par_bad_q, par_bad_d;
    logic                  parity_err_q, parity_err_d;
`endif

    assign rx_s     = rx_sync_q[1];
    assign half_hit = (cnt_q == ((div_q >> 1) - DivWidth'(1)));
    assign full_hit = (cnt_q == (div_q - DivWidth'(1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
`ifdef CHESHIRE_UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef CHESHIRE_UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (en_i && rx_prev_q && !rx_s) begin
                    state_d = START;
                    div_d   = (clk_div_i < DivWidth'(MinDiv)) ? DivWidth'(MinDiv) : clk_div_i;
                end
            end
            // Mid start bit: a line back high means it was a glitch.
            START: begin
                if (half_hit) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
            DATA: begin
                if (full_hit) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DataWidth-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef CHESHIRE_UART_RX_PARITY_EN
                        state_d = parity_en_i ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
`ifdef CHESHIRE_UART_RX_PARITY_EN
            // Even parity: data XOR parity bit must be 0; odd: must be 1.
            PARITY: begin
                if (full_hit) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rx_s ^ parity_odd_i;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
`endif
            STOP: begin
                if (full_hit) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef CHESHIRE_UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
            // A low stop bit may be a break; do not hunt for a start edge
            // until the line has recovered.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop       = valid_o & ready_i;
    assign overrun_d = push_req & fifo_full & ~pop;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rx_sync_q   <= 2'b11;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CHESHIRE_UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_sync_q   <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q   <= rx_s;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef CHESHIRE_UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    fifo_v3 #(
        .DATA_WIDTH (DataWidth),
        .DEPTH      (FifoDepth)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (shift_q),
        .push_i  (push_req),
        .data_o  (data_o),
        .pop_i   (pop)
    );

    assign valid_o     = ~fifo_empty;
    assign busy_o      = (state_q != IDLE);
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
`ifdef CHESHIRE_UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule
